// File: rtl/alu_pkg.sv
// Shared constants for the multicycle ALU: operation codes, flag bit positions
// and the sequencer state encoding.
package alu_pkg;

    localparam int unsigned FUN_W  = 5;
    localparam int unsigned FLAG_W = 4;

    localparam logic [FUN_W-1:0] FN_PASS_A = 5'h00;
    localparam logic [FUN_W-1:0] FN_PASS_B = 5'h01;
    localparam logic [FUN_W-1:0] FN_NOT_A  = 5'h02;
    localparam logic [FUN_W-1:0] FN_NOT_B  = 5'h03;
    localparam logic [FUN_W-1:0] FN_ADD    = 5'h04;
    localparam logic [FUN_W-1:0] FN_ADC    = 5'h05;
    localparam logic [FUN_W-1:0] FN_SUB    = 5'h06;
    localparam logic [FUN_W-1:0] FN_AND    = 5'h07;
    localparam logic [FUN_W-1:0] FN_OR     = 5'h08;
    localparam logic [FUN_W-1:0] FN_XOR    = 5'h09;
    localparam logic [FUN_W-1:0] FN_NAND   = 5'h0A;
    localparam logic [FUN_W-1:0] FN_LSL1   = 5'h0B;
    localparam logic [FUN_W-1:0] FN_LSR1   = 5'h0C;
    localparam logic [FUN_W-1:0] FN_ASR1   = 5'h0D;
    localparam logic [FUN_W-1:0] FN_CSL1   = 5'h0E;
    localparam logic [FUN_W-1:0] FN_CSR1   = 5'h0F;
    localparam logic [FUN_W-1:0] FN_MUL    = 5'h10;
    localparam logic [FUN_W-1:0] FN_LSL    = 5'h11;
    localparam logic [FUN_W-1:0] FN_LSR    = 5'h12;
    localparam logic [FUN_W-1:0] FN_ASR    = 5'h13;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath (codes 0x00-0x0F); codes above that pass A through
// with no carry/overflow contribution.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [FUN_W-1:0] fun,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             carry_en,
    output logic             overflow_en
);
    localparam int unsigned SUM_W = WIDTH + 1;

    logic [WIDTH-1:0] b_op;
    logic             add_cin;
    logic [WIDTH:0]   sum;

    // Shared adder: subtract is A + ~B + 1, add-with-carry takes the latched C.
    always_comb begin
        b_op    = (fun == FN_SUB) ? ~b : b;
        add_cin = (fun == FN_SUB) ? 1'b1 : ((fun == FN_ADC) ? cin : 1'b0);
        sum     = {1'b0, a} + {1'b0, b_op} + SUM_W'(add_cin);
    end

    always_comb begin
        result      = a;
        carry       = 1'b0;
        overflow    = 1'b0;
        carry_en    = 1'b0;
        overflow_en = 1'b0;
        case (fun)
            FN_PASS_A: result = a;
            FN_PASS_B: result = b;
            FN_NOT_A:  result = ~a;
            FN_NOT_B:  result = ~b;
            FN_ADD, FN_ADC, FN_SUB: begin
                result      = sum[WIDTH-1:0];
                carry       = sum[WIDTH];
                overflow    = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                carry_en    = 1'b1;
                overflow_en = 1'b1;
            end
            FN_AND:  result = a & b;
            FN_OR:   result = a | b;
            FN_XOR:  result = a ^ b;
            FN_NAND: result = ~(a & b);
            FN_LSL1: begin
                result   = {a[WIDTH-2:0], 1'b0};
                carry    = a[WIDTH-1];
                carry_en = 1'b1;
            end
            FN_LSR1: begin
                result   = {1'b0, a[WIDTH-1:1]};
                carry    = a[0];
                carry_en = 1'b1;
            end
            FN_ASR1: begin
                result   = {a[WIDTH-1], a[WIDTH-1:1]};
                carry    = a[0];
                carry_en = 1'b1;
            end
            FN_CSL1: begin
                result   = {a[WIDTH-2:0], cin};
                carry    = a[WIDTH-1];
                carry_en = 1'b1;
            end
            FN_CSR1: begin
                result   = {cin, a[WIDTH-1:1]};
                carry    = a[0];
                carry_en = 1'b1;
            end
            default: result = a;
        endcase
    end

endmodule

// File: rtl/multicycle_alu.sv
// Request/response ALU: single-cycle ops via alu_comb_core, plus an iterative
// shift-add multiplier and one-bit-per-cycle barrel-free shifter.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [FUN_W-1:0]  FunSel,
    input  logic [SHW-1:0]    ShAmt,
    input  logic              WF,
    input  logic              InValid,
    output logic              InReady,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [WIDTH-1:0]  ALUOut,
    output logic [FLAG_W-1:0] FlagsOut
);
    localparam int unsigned CW_MIN = $clog2(WIDTH + 1);
    localparam int unsigned CNT_W  = (SHW > CW_MIN) ? SHW : CW_MIN;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [FUN_W-1:0]   fun_q;
    logic [SHW-1:0]     sh_q;
    logic               wf_q;
    logic               cin_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   work;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0]   core_res;
    logic               core_c;
    logic               core_o;
    logic               core_c_en;
    logic               core_o_en;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH-1:0]   work_nx;
    logic               shout_nx;
    logic [CNT_W-1:0]   last_cnt;
    logic               finish;
    logic               is_shift;
    logic [WIDTH-1:0]   res_c;
    logic               c_val;
    logic               o_val;
    logic               c_en;
    logic               o_en;
    logic [FLAG_W-1:0]  flags_nx;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .a           (a_q),
        .b           (b_q),
        .fun         (fun_q),
        .cin         (cin_q),
        .result      (core_res),
        .carry       (core_c),
        .overflow    (core_o),
        .carry_en    (core_c_en),
        .overflow_en (core_o_en)
    );

    // One iteration step of the multiplier and the serial shifter.
    always_comb begin
        is_shift = (fun_q == FN_LSL) || (fun_q == FN_LSR) || (fun_q == FN_ASR);
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        prod_nx  = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
        work_nx  = work;
        shout_nx = 1'b0;
        case (fun_q)
            FN_LSL: begin
                work_nx  = {work[WIDTH-2:0], 1'b0};
                shout_nx = work[WIDTH-1];
            end
            FN_LSR: begin
                work_nx  = {1'b0, work[WIDTH-1:1]};
                shout_nx = work[0];
            end
            FN_ASR: begin
                work_nx  = {work[WIDTH-1], work[WIDTH-1:1]};
                shout_nx = work[0];
            end
            default: ;
        endcase
        last_cnt = '0;
        if (fun_q == FN_MUL) begin
            last_cnt = CNT_W'(WIDTH - 1);
        end else if (is_shift && (sh_q != '0)) begin
            last_cnt = CNT_W'(sh_q) - CNT_W'(1);
        end
        finish = (cnt == last_cnt);
    end

    // Final result and flag candidates, selected by the latched operation.
    always_comb begin
        res_c = core_res;
        c_val = core_c;
        o_val = core_o;
        c_en  = core_c_en;
        o_en  = core_o_en;
        if (fun_q == FN_MUL) begin
            res_c = prod_nx[WIDTH-1:0];
            c_val = |prod_nx[2*WIDTH-1:WIDTH];
            o_val = |prod_nx[2*WIDTH-1:WIDTH];
            c_en  = 1'b1;
            o_en  = 1'b1;
        end else if (is_shift) begin
            res_c = (sh_q == '0) ? a_q : work_nx;
            c_val = shout_nx;
            c_en  = (sh_q != '0);
            o_en  = 1'b0;
        end
        flags_nx         = FlagsOut;
        flags_nx[FLAG_Z] = (res_c == '0);
        flags_nx[FLAG_N] = res_c[WIDTH-1];
        if (c_en) flags_nx[FLAG_C] = c_val;
        if (o_en) flags_nx[FLAG_O] = o_val;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            ALUOut   <= '0;
            FlagsOut <= '0;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            sh_q     <= '0;
            wf_q     <= 1'b0;
            cin_q    <= 1'b0;
            cnt      <= '0;
            work     <= '0;
            prod     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (InValid) begin
                        a_q     <= A;
                        b_q     <= B;
                        fun_q   <= FunSel;
                        sh_q    <= ShAmt;
                        wf_q    <= WF;
                        cin_q   <= FlagsOut[FLAG_C];
                        cnt     <= '0;
                        work    <= A;
                        prod    <= {{WIDTH{1'b0}}, B};
                        InReady <= 1'b0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    prod <= prod_nx;
                    work <= work_nx;
                    cnt  <= cnt + CNT_W'(1);
                    if (finish) begin
                        ALUOut   <= res_c;
                        OutValid <= 1'b1;
                        if (wf_q) FlagsOut <= flags_nx;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (OutReady) begin
                        OutValid <= 1'b0;
                        InReady  <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    InReady  <= 1'b1;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an arithmetic
// reference model of each operation, its flags and its latency.
module tb_multicycle_alu;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;
    localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint SMIN = -64'sh0000_0000_8000_0000;

    logic             Clock;
    logic             Reset;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       FunSel;
    logic [SHW-1:0]   ShAmt;
    logic             WF;
    logic             InValid;
    logic             InReady;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] ALUOut;
    logic [3:0]       FlagsOut;

    int         passed;
    int         total;
    logic [3:0] mflags;

    multicycle_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .A        (A),
        .B        (B),
        .FunSel   (FunSel),
        .ShAmt    (ShAmt),
        .WF       (WF),
        .InValid  (InValid),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: result, {Z,C,N,O} and edges from accept to OutValid.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                                  input logic [4:0] s, input logic wf, input logic [3:0] fin,
                                  output logic [31:0] res, output logic [3:0] fo, output int lat);
        logic [63:0] w;
        longint      sv;
        logic        c, o, uc, uo, ci;
        int          n;
        n   = int'(s);
        c   = fin[2];
        o   = fin[0];
        uc  = 1'b0;
        uo  = 1'b0;
        lat = 2;
        res = a;
        ci  = (f == 5'h05) ? fin[2] : 1'b0;
        case (f)
            5'h00: res = a;
            5'h01: res = b;
            5'h02: res = ~a;
            5'h03: res = ~b;
            5'h04, 5'h05: begin
                w   = 64'(a) + 64'(b) + 64'(ci);
                sv  = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
                res = w[31:0];
                c   = w[32];
                o   = (sv > SMAX) || (sv < SMIN);
                uc  = 1'b1;
                uo  = 1'b1;
            end
            5'h06: begin
                sv  = longint'($signed(a)) - longint'($signed(b));
                res = a - b;
                c   = (a >= b);
                o   = (sv > SMAX) || (sv < SMIN);
                uc  = 1'b1;
                uo  = 1'b1;
            end
            5'h07: res = a & b;
            5'h08: res = a | b;
            5'h09: res = a ^ b;
            5'h0A: res = ~(a & b);
            5'h0B: begin res = a << 1; c = a[31]; uc = 1'b1; end
            5'h0C: begin res = a >> 1; c = a[0]; uc = 1'b1; end
            5'h0D: begin res = 32'($signed(a) >>> 1); c = a[0]; uc = 1'b1; end
            5'h0E: begin res = {a[30:0], fin[2]}; c = a[31]; uc = 1'b1; end
            5'h0F: begin res = {fin[2], a[31:1]}; c = a[0]; uc = 1'b1; end
            5'h10: begin
                w   = 64'(a) * 64'(b);
                res = w[31:0];
                c   = (w[63:32] != 32'd0);
                o   = c;
                uc  = 1'b1;
                uo  = 1'b1;
                lat = 33;
            end
            5'h11, 5'h12, 5'h13: begin
                lat = ((n == 0) ? 1 : n) + 1;
                if (n != 0) begin
                    uc = 1'b1;
                    if (f == 5'h11) begin res = a << n; c = a[32-n]; end
                    else if (f == 5'h12) begin res = a >> n; c = a[n-1]; end
                    else begin res = 32'($signed(a) >>> n); c = a[n-1]; end
                end
            end
            default: res = a;
        endcase
        fo = fin;
        if (wf) begin
            fo[3] = (res == 32'd0);
            fo[1] = res[31];
            if (uc) fo[2] = c;
            if (uo) fo[0] = o;
        end
    endfunction

    task automatic wait_done(output int lat);
        lat = 1;
        while (OutValid !== 1'b1 && lat < 100) begin
            @(posedge Clock); #1;
            lat++;
        end
    endtask

    task automatic ack();
        @(negedge Clock);
        OutReady = 1'b1;
        @(posedge Clock); #1;
        OutReady = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] f,
                          input logic [4:0] s, input logic wf,
                          output logic [31:0] res, output logic [3:0] fl, output int lat);
        @(negedge Clock);
        A = a; B = b; FunSel = f; ShAmt = s; WF = wf; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        wait_done(lat);
        res = ALUOut;
        fl  = FlagsOut;
        ack();
    endtask

    task automatic test_reset();
        InValid = 1'b0; OutReady = 1'b0; A = '0; B = '0; FunSel = '0; ShAmt = '0; WF = 1'b0;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        total++; if (ALUOut !== 32'd0) $display("FAIL reset_aluout: got %h expected 0", ALUOut); else passed++;
        total++; if (FlagsOut !== 4'd0) $display("FAIL reset_flags: got %b expected 0000", FlagsOut); else passed++;
        total++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid: got %b expected 0", OutValid); else passed++;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        total++; if (InReady !== 1'b1) $display("FAIL reset_inready: got %b expected 1", InReady); else passed++;
        mflags = 4'd0;
    endtask

    task automatic test_directed();
        logic [31:0] da [5];
        logic [31:0] db [5];
        logic [4:0]  df [5];
        logic [4:0]  ds [5];
        logic        dw [5];
        logic [31:0] er [5];
        logic [3:0]  ef [5];
        int          el [5];
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
        da = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0001_0000, 32'h8000_0000, 32'h1234_5678};
        db = '{32'h1, 32'h1, 32'h0001_0000, 32'h0, 32'h0};
        df = '{5'h04, 5'h04, 5'h10, 5'h13, 5'h13};
        ds = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0};
        dw = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        er = '{32'h0, 32'h8000_0000, 32'h0, 32'hF800_0000, 32'h1234_5678};
        ef = '{4'b1100, 4'b1100, 4'b1101, 4'b0011, 4'b0011};
        el = '{2, 2, 33, 5, 2};
        for (int i = 0; i < 5; i++) begin
            run_op(da[i], db[i], df[i], ds[i], dw[i], res, fl, lat);
            total++; if (res !== er[i]) $display("FAIL directed%0d_result: got %h expected %h", i, res, er[i]); else passed++;
            total++; if (fl !== ef[i]) $display("FAIL directed%0d_flags: got %b expected %b", i, fl, ef[i]); else passed++;
            total++; if (lat !== el[i]) $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, el[i]); else passed++;
        end
        mflags = 4'b0011;
    endtask

    task automatic test_random_ops();
        logic [31:0] corners [4];
        logic [31:0] a, b, res, eres;
        logic [4:0]  f, s;
        logic        wf;
        logic [3:0]  fl, efl;
        int          lat, elat;
        corners = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 80; i++) begin
            f  = (i < 32) ? 5'(i) : 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            s  = 5'($urandom_range(0, 31));
            wf = ($urandom_range(0, 4) != 0);
            model(a, b, f, s, wf, mflags, eres, efl, elat);
            run_op(a, b, f, s, wf, res, fl, lat);
            total++; if (res !== eres) $display("FAIL rand%0d_result f=%h: got %h expected %h", i, f, res, eres); else passed++;
            total++; if (fl !== efl) $display("FAIL rand%0d_flags f=%h: got %b expected %b", i, f, fl, efl); else passed++;
            total++; if (lat !== elat) $display("FAIL rand%0d_latency f=%h: got %0d expected %0d", i, f, lat, elat); else passed++;
            mflags = efl;
        end
    endtask

    task automatic test_hold();
        logic [31:0] a, b, eres;
        logic [3:0]  efl;
        int          lat, elat;
        a = $urandom; b = $urandom;
        model(a, b, 5'h04, 5'd0, 1'b1, mflags, eres, efl, elat);
        @(negedge Clock);
        A = a; B = b; FunSel = 5'h04; ShAmt = '0; WF = 1'b1; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        wait_done(lat);
        total++; if (lat !== elat) $display("FAIL hold_latency: got %0d expected %0d", lat, elat); else passed++;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            InValid = (k % 2 == 0);
            A = $urandom; B = $urandom; FunSel = 5'($urandom_range(0, 31));
            @(posedge Clock); #1;
            total++; if (OutValid !== 1'b1) $display("FAIL hold%0d_outvalid: got %b expected 1", k, OutValid); else passed++;
            total++; if (ALUOut !== eres) $display("FAIL hold%0d_aluout: got %h expected %h", k, ALUOut, eres); else passed++;
            total++; if (InReady !== 1'b0) $display("FAIL hold%0d_inready: got %b expected 0", k, InReady); else passed++;
        end
        @(negedge Clock);
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock); #1;
        OutReady = 1'b0;
        total++; if (FlagsOut !== efl) $display("FAIL hold_flags: got %b expected %b", FlagsOut, efl); else passed++;
        repeat (3) @(posedge Clock);
        #1;
        total++; if (OutValid !== 1'b0) $display("FAIL hold_no_queue_outvalid: got %b expected 0", OutValid); else passed++;
        total++; if (InReady !== 1'b1) $display("FAIL hold_no_queue_inready: got %b expected 1", InReady); else passed++;
        mflags = efl;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, r1, r2;
        logic [3:0]  f1, f2;
        int          l1, l2, lat;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        model(a1, b1, 5'h06, 5'd0, 1'b1, mflags, r1, f1, l1);
        model(a2, b2, 5'h05, 5'd0, 1'b1, f1, r2, f2, l2);
        @(negedge Clock);
        A = a1; B = b1; FunSel = 5'h06; ShAmt = '0; WF = 1'b1; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        wait_done(lat);
        total++; if (ALUOut !== r1) $display("FAIL b2b_first_result: got %h expected %h", ALUOut, r1); else passed++;
        @(negedge Clock);
        OutReady = 1'b1;
        A = a2; B = b2; FunSel = 5'h05; WF = 1'b1; InValid = 1'b1;
        @(posedge Clock); #1;
        OutReady = 1'b0;
        total++; if (InReady !== 1'b1) $display("FAIL b2b_idle_inready: got %b expected 1", InReady); else passed++;
        total++; if (OutValid !== 1'b0) $display("FAIL b2b_idle_outvalid: got %b expected 0", OutValid); else passed++;
        @(posedge Clock); #1;
        InValid = 1'b0;
        total++; if (InReady !== 1'b0) $display("FAIL b2b_accept_inready: got %b expected 0", InReady); else passed++;
        wait_done(lat);
        total++; if (lat !== l2) $display("FAIL b2b_second_latency: got %0d expected %0d", lat, l2); else passed++;
        total++; if (ALUOut !== r2) $display("FAIL b2b_second_result: got %h expected %h", ALUOut, r2); else passed++;
        total++; if (FlagsOut !== f2) $display("FAIL b2b_second_flags: got %b expected %b", FlagsOut, f2); else passed++;
        ack();
        mflags = f2;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b, res, eres;
        logic [3:0]  fl, efl;
        int          lat, elat;
        @(negedge Clock);
        A = 32'hDEAD_BEEF; B = 32'h1234_5679; FunSel = 5'h10; ShAmt = '0; WF = 1'b1; InValid = 1'b1;
        @(posedge Clock); #1;
        InValid = 1'b0;
        repeat (4) @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        total++; if (ALUOut !== 32'd0) $display("FAIL midreset_aluout: got %h expected 0", ALUOut); else passed++;
        total++; if (FlagsOut !== 4'd0) $display("FAIL midreset_flags: got %b expected 0000", FlagsOut); else passed++;
        total++; if (OutValid !== 1'b0) $display("FAIL midreset_outvalid: got %b expected 0", OutValid); else passed++;
        @(negedge Clock);
        Reset = 1'b1;
        mflags = 4'd0;
        repeat (40) @(posedge Clock);
        #1;
        total++; if (OutValid !== 1'b0) $display("FAIL midreset_discarded: got %b expected 0", OutValid); else passed++;
        a = $urandom; b = $urandom;
        model(a, b, 5'h04, 5'd0, 1'b1, mflags, eres, efl, elat);
        run_op(a, b, 5'h04, 5'd0, 1'b1, res, fl, lat);
        total++; if (res !== eres) $display("FAIL postreset_result: got %h expected %h", res, eres); else passed++;
        total++; if (fl !== efl) $display("FAIL postreset_flags: got %b expected %b", fl, efl); else passed++;
        total++; if (lat !== elat) $display("FAIL postreset_latency: got %0d expected %0d", lat, elat); else passed++;
        mflags = efl;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_directed();
        test_random_ops();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, even).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named Clock and Reset; polarity and synchronicity are fixed.
REQ-004 SHALL have ports, in this order:
- Clock  in  1  rising-edge clock.
- Reset  in  1  async active-low reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- FunSel  in  5  operation code.
- ShAmt  in  SHW  multi-bit shift amount.
- WF  in  1  write-flags enable for this operation.
- InValid  in  1  request valid.
- InReady  out  1  block can accept a request.
- OutValid  out  1  ALUOut valid.
- OutReady  in  1  consumer accepts result.
- ALUOut  out  WIDTH  registered result.
- FlagsOut  out  4  {Z,C,N,O}, MSB first.

Function
REQ-005 SHALL accept a request on a rising edge with InValid=1 and InReady=1, latching A, B, FunSel, ShAmt and WF.
REQ-006 SHALL implement the FSM: IDLE -> BUSY on accept; BUSY -> DONE when the operation completes; DONE -> IDLE when OutReady=1.
REQ-007 SHALL drive InReady=1 only in IDLE and OutValid=1 only in DONE.
REQ-008 SHALL hold ALUOut and OutValid stable in DONE until OutReady=1, however long that takes.
REQ-009 Single-cycle codes 0x00-0x0F SHALL be, in order:
- A, B, ~A, ~B.
- A+B, A+B+C, A-B.
- AND, OR, XOR, NAND.
- LSL1, LSR1, ASR1.
- CSL1 (C in at bit 0), CSR1 (C in at MSB).
These SHALL spend 1 cycle in BUSY, so OutValid rises 2 edges after accept.
REQ-010 Code 0x10 SHALL be an unsigned shift-add multiply taking WIDTH BUSY cycles; ALUOut = low WIDTH bits of the product.
REQ-011 Codes 0x11/0x12/0x13 SHALL be LSL/LSR/ASR by ShAmt, one bit per BUSY cycle, taking max(ShAmt,1) cycles.
- ShAmt=0 returns A unchanged.
REQ-012 Codes 0x14-0x1F SHALL return A in 1 cycle and update only Z and N.
REQ-013 Flags SHALL update on the BUSY->DONE edge, and only if the latched WF=1:
- Z = (result==0); N = result MSB, for all ops.
- C for add: carry out. C for sub: carry of A+~B+1. C for shift/rotate: last bit shifted out.
- C for multiply: high product half nonzero.
- O for add/sub: two's-complement overflow. O for multiply: equals C.
- All other flag bits hold their value.
REQ-014 A+B+C and the rotates SHALL use the C value in FlagsOut at accept time.
REQ-015 InValid while not IDLE SHALL be ignored; no request is queued.
REQ-016 Simultaneous OutReady=1 and InValid=1 in DONE SHALL only return to IDLE; the new request is accepted next cycle.

Reset
REQ-017 Reset low SHALL immediately force:
- state IDLE.
- ALUOut=0, FlagsOut=0.
- OutValid=0, InReady=1 once released.
REQ-018 Reset asserted mid-BUSY or in DONE SHALL discard the operation with no flag update.

Structure
REQ-019 Package alu_pkg SHALL hold the FunSel code constants, the flag bit indices (Z=3, C=2, N=1, O=0) and the FSM state enum.
REQ-020 The single-cycle datapath SHALL be sub-module alu_comb_core (WIDTH-parametrised, combinational, carry/overflow outputs); the FSM, multiply and shift iterators stay in multicycle_alu.

Verification
REQ-021 WIDTH=32: A=0xFFFFFFFF, B=1, FunSel=0x04, WF=1 -> ALUOut=0, FlagsOut=1100 (O=0), OutValid 2 edges after accept.
REQ-022 A=0x7FFFFFFF, B=1, add, WF=0 -> ALUOut=0x80000000, FlagsOut unchanged.
REQ-023 A=0x00010000, B=0x00010000, FunSel=0x10, WF=1 -> ALUOut=0, Z=1, C=1, O=1, OutValid exactly WIDTH+1 edges after accept.
REQ-024 A=0x80000000, ShAmt=4, FunSel=0x13 -> ALUOut=0xF8000000, N=1; then ShAmt=0 -> ALUOut=A after 2 edges.
REQ-025 Hold OutReady=0 for 10 cycles in DONE -> ALUOut stable and InReady=0; InValid pulses during this time are ignored.
REQ-026 Assert Reset during a multiply (cycle 5) -> ALUOut=0, FlagsOut=0, OutValid=0; a fresh add completes normally.
